// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction-fetch initiator for mips_cpu_harvard.
// Owns the program counter, drives the Harvard instruction port and applies
// branch/jump redirects with one-instruction delay-slot semantics.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   clk_enable, stall   global enable / hold request; either freezes all state
//   redirect_valid      instruction at pc is a taken branch/jump
//   redirect_target     destination of that branch/jump
//   instr_readdata      word at instr_address (combinational memory)
//   instr_address       fetch address (equals pc)
//   instr               instr_readdata while active, else nop
//   pc, pc_plus8        current instruction address and its link value
//   in_delay_slot       current instruction is a delay slot
//   active              1 while running, 0 once halted
//   addr_fault          sticky misaligned-redirect flag
module mips_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instr_address,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic        in_delay_slot,
    output logic        active,
    output logic        addr_fault
);

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DELAY  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] pending_target;
    logic [31:0] pending_nxt;
    logic        fault_nxt;
    logic        adv;

    // State register; reset wins over enable and stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            pc             <= RESET_VECTOR;
            pending_target <= 32'h0;
            addr_fault     <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            pending_target <= pending_nxt;
            addr_fault     <= fault_nxt;
        end
    end

    // Next-state logic: linear fetch, delay-slot redirect, halt and fault.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pending_nxt = pending_target;
        fault_nxt   = addr_fault;
        adv         = clk_enable & ~stall & (state != HALTED);

        if (adv) begin
            case (state)
                RUN: begin
                    pc_nxt = pc + 32'(WORD_BYTES);
                    if (redirect_valid) begin
                        pending_nxt = redirect_target;
                        state_nxt   = DELAY;
                        if (redirect_target[1:0] != 2'b00) begin
                            fault_nxt = 1'b1;
                        end
                    end
                end
                DELAY: begin
                    // Later redirects are ignored here: the first one wins.
                    // A misaligned target stops fetch at the delay-slot address.
                    if (pending_target[1:0] != 2'b00) begin
                        state_nxt = HALTED;
                    end else begin
                        pc_nxt    = pending_target;
                        state_nxt = RUN;
                    end
                end
                default: ;
            endcase

            // Reaching the halt address stops fetch, including via wraparound.
            if (pc_nxt == HALT_ADDR) begin
                state_nxt = HALTED;
            end
        end
    end

    assign instr_address = pc;
    assign pc_plus8      = pc + 32'(2 * WORD_BYTES);
    assign in_delay_slot = (state == DELAY);
    assign active        = (state != HALTED);
    assign instr         = active ? instr_readdata : 32'h0;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios with literal
// expectations, then random stimulus against a fetch-sequence model.
module tb_mips_fetch_unit;

    localparam logic [31:0] RV    = 32'hBFC00000;
    localparam logic [31:0] HALT  = 32'h00000000;
    localparam logic [31:0] MEMK  = 32'h5A5A3C3C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] instr_readdata;
    logic [31:0] instr_address;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        in_delay_slot;
    logic        active;
    logic        addr_fault;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    // Model: pc, a queue of addresses already committed to be fetched next,
    // a halted flag and the sticky fault flag.
    logic [31:0] m_pc = RV;
    logic [31:0] m_q[$];
    bit          m_halted = 1'b0;
    bit          m_fault = 1'b0;

    mips_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .clk_enable      (clk_enable),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_readdata  (instr_readdata),
        .instr_address   (instr_address),
        .instr           (instr),
        .pc              (pc),
        .pc_plus8        (pc_plus8),
        .in_delay_slot   (in_delay_slot),
        .active          (active),
        .addr_fault      (addr_fault)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory: content is a function of address.
    always_comb instr_readdata = instr_address ^ MEMK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the sampled inputs.
    task automatic model_edge(input bit rst, input bit en, input bit st,
                              input bit rv, input logic [31:0] tgt);
        logic [31:0] nxt;
        if (rst) begin
            m_pc = RV;
            m_q.delete();
            m_halted = 1'b0;
            m_fault = 1'b0;
            return;
        end
        if (!en || st || m_halted) return;
        if (m_q.size() == 0) begin
            nxt = m_pc + 32'd4;
            if (rv) begin
                m_q.push_back(tgt);
                if (tgt % 4 != 0) m_fault = 1'b1;
            end
        end else begin
            nxt = m_q.pop_front();
            if (nxt % 4 != 0) begin
                m_halted = 1'b1;
                return;
            end
        end
        m_pc = nxt;
        if (m_pc == HALT) begin
            m_halted = 1'b1;
            m_q.delete();
        end
    endtask

    // Compare process: every falling edge once reset has been applied.
    always @(negedge clk) begin
        if (checking) begin
            chk("pc", pc, m_pc);
            chk("instr_address", instr_address, m_pc);
            chk("pc_plus8", pc_plus8, m_pc + 32'd8);
            chk("in_delay_slot", 32'(in_delay_slot), 32'(m_q.size() != 0));
            chk("active", 32'(active), 32'(!m_halted));
            chk("addr_fault", 32'(addr_fault), 32'(m_fault));
            chk("instr", instr, m_halted ? 32'h0 : (m_pc ^ MEMK));
        end
    end

    task automatic step(input bit rst, input bit en, input bit st,
                        input bit rv, input logic [31:0] tgt);
        reset = rst;
        clk_enable = en;
        stall = st;
        redirect_valid = rv;
        redirect_target = tgt;
        @(posedge clk);
        model_edge(rst, en, st, rv, tgt);
        checking = 1'b1;
        @(negedge clk);
    endtask

    task automatic adv1();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        bit          rst, en, st, rv;
        logic [31:0] tgt;
        int unsigned sel;

        @(negedge clk);

        // Reset state and linear fetch.
        do_reset();
        chk("lit_reset_pc", pc, 32'hBFC00000);
        chk("lit_reset_pc8", pc_plus8, 32'hBFC00008);
        chk("lit_reset_active", 32'(active), 32'd1);
        chk("lit_reset_fault", 32'(addr_fault), 32'd0);
        adv1(); chk("lit_lin1", instr_address, 32'hBFC00004);
        adv1(); chk("lit_lin2", instr_address, 32'hBFC00008);
        adv1(); chk("lit_lin3", instr_address, 32'hBFC0000C);
        chk("lit_lin_active", 32'(active), 32'd1);

        // Halt via jr $zero.
        do_reset(); adv1(); adv1();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        chk("lit_halt_ds_pc", pc, 32'hBFC0000C);
        chk("lit_halt_ds", 32'(in_delay_slot), 32'd1);
        adv1();
        chk("lit_halt_pc", pc, 32'h0);
        chk("lit_halt_active", 32'(active), 32'd0);
        chk("lit_halt_instr", instr, 32'h0);
        repeat (10) adv1();
        chk("lit_halt_hold", pc, 32'h0);

        // Stall then clock-enable low.
        do_reset(); adv1();
        repeat (3) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("lit_stall_hold", pc, 32'hBFC00004);
        end
        repeat (2) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("lit_en_hold", pc, 32'hBFC00004);
        end
        adv1(); chk("lit_stall_resume", pc, 32'hBFC00008);

        // Branch in the delay slot is ignored.
        do_reset();
        chk("lit_br_pc8", pc_plus8, 32'hBFC00008);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hBFC00100);
        chk("lit_br_ds", pc, 32'hBFC00004);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hBFC00200);
        chk("lit_br_tgt", pc, 32'hBFC00100);
        adv1(); chk("lit_br_next", pc, 32'hBFC00104);

        // Misaligned redirect target.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hBFC00102);
        adv1();
        chk("lit_fault_flag", 32'(addr_fault), 32'd1);
        chk("lit_fault_active", 32'(active), 32'd0);
        chk("lit_fault_pc", pc, 32'hBFC00004);

        // Reset during the delay slot discards the target.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hBFC00100);
        do_reset(); chk("lit_rstds_pc", pc, 32'hBFC00000);
        adv1(); chk("lit_rstds_next", pc, 32'hBFC00004);

        // Wraparound from the top of the address space halts.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFF8);
        adv1(); chk("lit_wrap_a", pc, 32'hFFFFFFF8);
        adv1(); chk("lit_wrap_b", pc, 32'hFFFFFFFC);
        adv1();
        chk("lit_wrap_pc", pc, 32'h0);
        chk("lit_wrap_active", 32'(active), 32'd0);

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 5) == 0);
            en  = ($urandom_range(0, 9) != 0);
            st  = ($urandom_range(0, 5) == 0);
            rv  = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 19);
            if (sel == 0)
                tgt = HALT;
            else if (sel == 1)
                tgt = RV + 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(1, 3));
            else if (sel == 2)
                tgt = 32'hFFFFFFF8;
            else
                tgt = RV + 32'($urandom_range(0, 1023)) * 32'd4;
            step(rst, en, st, rv, tgt);
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction-fetch initiator for `mips_cpu_harvard`; it owns the program counter and drives the Harvard instruction port (`instr_address` out, `instr_readdata` in). It sequences linear fetch from the reset vector and applies branch/jump redirects with MIPS one-instruction delay-slot semantics. It detects the halt condition (control transfer to address 0) and reports it on `active`. It faces the same combinational instruction memory the CPU testbenches provide and feeds the decode/execute stage.

## Interface
- `RESET_VECTOR`, default 32'hBFC00000, first fetch address after reset
- `HALT_ADDR`, default 32'h00000000, reaching this PC stops fetch
- `clk` input 1: sole clock, rising-edge
- `reset` input 1: synchronous, active-high
- `clk_enable` input 1: global enable; 0 freezes all state
- `stall` input 1: hold current PC and state (data hazard/memory wait)
- `redirect_valid` input 1: instruction currently at `pc` is a taken branch/jump
- `redirect_target` input 32: destination of that branch/jump
- `instr_readdata` input 32: word at `instr_address`, combinational from memory
- `instr_address` output 32: fetch address, equals `pc`
- `instr` output 32: `instr_readdata` passthrough when `active`=1, else 32'h0 (nop)
- `pc` output 32: address of instruction being executed
- `pc_plus8` output 32: link value for JAL/JALR/BGEZAL/BLTZAL
- `in_delay_slot` output 1: current instruction is a delay slot
- `active` output 1: 1 while running, 0 once halted
- `addr_fault` output 1: sticky, misaligned redirect target seen

## Operation
- Registered state: `pc`, `pending_target`, state enum {RUN, DELAY, HALTED}, `addr_fault`.
- Advance condition: `adv = clk_enable & ~stall & (state != HALTED)`. When `adv`=0, no register changes; outputs hold.
- RUN: on `adv`: `pc <= pc+4`. If `redirect_valid`: latch `pending_target <= redirect_target`, go DELAY.
- DELAY (`in_delay_slot`=1): delay-slot instruction executes at `pc`. On `adv`: `pc <= pending_target`, go RUN. `redirect_valid` here (branch in delay slot) is ignored; the first redirect wins.
- Halt: whenever the next `pc` equals `HALT_ADDR`, the next state is HALTED, `active` goes 0, and `pc`/`instr_address` stay at `HALT_ADDR`. HALTED is left only by `reset`.
- Fault: `redirect_valid` with `redirect_target[1:0] != 0` sets `addr_fault`, goes directly to HALTED after the delay slot, and leaves `pc` at the delay-slot address.
- Arithmetic: `pc+4` and `pc+8` are 32-bit modulo. 32'hFFFFFFFC+4 wraps to 0 and therefore halts.

## Timing
- Reset (synchronous, sampled on `clk` rising): `pc`=`instr_address`=`RESET_VECTOR`, state RUN, `active`=1, `in_delay_slot`=0, `addr_fault`=0, `pending_target`=0, `pc_plus8`=`RESET_VECTOR`+8.
- `reset` has priority over `clk_enable` and `stall`. Reset mid-DELAY discards the pending target.
- Fetch latency 0: `instr` is valid in the same cycle `instr_address` changes, because memory is combinational.
- Redirect latency: exactly 2 advancing edges from the branch cycle to `pc`=target (branch, then delay slot).
- `active` falls on the same edge that loads `HALT_ADDR` into `pc`.
- `in_delay_slot`, `pc_plus8`, and `instr` are combinational from registered state and inputs.

## Test plan
- Linear fetch: reset, then 3 edges -> `instr_address` = BFC00000, BFC00004, BFC00008, BFC0000C; `active`=1 throughout.
- Halt via `jr $zero`: `redirect_valid`=1 with target 0 at `pc`=BFC00008 -> `pc`=BFC0000C with `in_delay_slot`=1, then `pc`=0 with `active`=0. Ten further edges leave `pc`=0.
- Stall/enable: assert `stall` at `pc`=BFC00004 for 3 cycles, then `clk_enable`=0 for 2 cycles -> `pc` holds BFC00004 for 5 cycles, then advances to BFC00008.
- Delay-slot branch: redirect to BFC00100 at BFC00000, then redirect to BFC00200 at BFC00004 -> `pc` goes BFC00004 then BFC00100. `pc_plus8` at the first branch = BFC00008.
- Fault: redirect target BFC00102 -> after the delay slot `addr_fault`=1, `active`=0, `pc`=BFC00004 (delay-slot address).
- Reset mid-DELAY: redirect to BFC00100, then `reset` during the delay-slot cycle -> `pc`=BFC00000 and BFC00100 is never fetched.
